priority_serial_tx: RTL and testbench
=====================================

// Module: priority_serial_tx
// PURPOSE
//  - Parametrised successor to the 4-input encoder/counter/latch/mux path.
//  - Accepts an N_CH-wide request vector with valid/ready handshake and
//    priority-encodes it (highest set bit wins).
//  - Latches the winning grant, then transmits the binary index on one serial line.
//  - Frame: start bit, index bits MSB first, optional parity bit, stop bit.
//  - Sits between request sources and a single-wire link to the downstream decoder.
// PARAMETERS
//  - N_CH   default 4  number of request channels, >= 2
//  - IDX_W  default 2  index width; must equal $clog2(N_CH)
// PORTS
//  - clk         input   1      rising-edge clock
//  - rst         input   1      synchronous reset, active-high
//  - i           input   N_CH   request vector, sampled on accept
//  - i_valid     input   1      request vector is valid
//  - i_ready     output  1      block can accept a request this cycle
//  - data        output  1      serial line; idles high
//  - busy        output  1      frame in progress (any state except IDLE)
//  - o           output  N_CH   latched one-hot grant of the last accepted frame
//  - idx         output  IDX_W  latched binary index of the last accepted frame
//  - frame_done  output  1      one-cycle pulse during the STOP cycle
// BEHAVIOUR
//  - Clocking and reset: one clock, clk; reset rst is synchronous and active-high.
//  - Reset values, all registered: data=1, busy=0, o=0, idx=0, frame_done=0,
//    state=IDLE.
//  - rst dominates every other input, including in mid-frame.
//    A frame in progress is aborted with no stop bit.
//  - Handshake:
//    - i_ready = (state==IDLE) || (state==STOP); combinational from state.
//    - Accept occurs on a clock edge with i_valid && i_ready && |i.
//    - i_valid with i==0 is ignored: no frame starts, and o/idx are unchanged.
//  - Encode: idx = position of the highest set bit of i; o = 1<<idx.
//    Both load on accept and hold until the next accept.
//  - FSM states: IDLE -> START -> SHIFT (IDX_W cycles) -> [PARITY] -> STOP.
//    - IDLE: data=1. On accept, go to START.
//    - START: data=0 for one cycle; shift counter loads IDX_W-1.
//    - SHIFT: data=idx[cnt]; cnt decrements; after cnt==0 go to PARITY or STOP.
//      cnt is not wrapped and is not reused.
//    - PARITY (only if compiled in): data=^idx for one cycle (even parity).
//    - STOP: data=1, frame_done=1.
//      If an accept happens on this edge, go to START (no idle gap).
//      Otherwise go to IDLE.
//  - Latency: data shows the start bit in the first cycle after the accept edge.
//  - Frame length: 2+IDX_W cycles, or 3+IDX_W with parity.
//  - Back-to-back throughput: one frame per 2+IDX_W (or 3+IDX_W) cycles.
//  - Changes to i or i_valid while busy and not in STOP have no effect.
//  - data, busy and frame_done are registered outputs (glitch-free).
// CONFIGURATION
//  - Macro PRIORITY_SERIAL_TX_PARITY_EN.
//  - Defined: the PARITY state is inserted after SHIFT and sends even parity (^idx).
//  - Undefined: no PARITY state; SHIFT goes directly to STOP.
//  - The macro has no other effect on ports or timing.
// TESTING (N_CH=4, IDX_W=2)
//  - Reset: hold rst for 2 cycles.
//    -> data=1, busy=0, o=0000, idx=00, i_ready=1, frame_done=0.
//  - Single request: i=0001, i_valid for 1 cycle.
//    -> data=0,0,0,1 over the next 4 cycles; o=0001; idx=0.
//    -> frame_done is high in the 4th cycle.
//  - Priority: i=1010.
//    -> idx=3, o=1000; data=0,1,1,1.
//    -> With PARITY_EN: data=0,1,1,0,1.
//  - Back-to-back: i=0100 valid, then i=0010 presented during STOP.
//    -> data=0,1,0,1,0,0,1,1 with no idle cycle between frames.
//    -> idx goes 2 then 1.
//  - Null request: i_valid=1 with i=0000 for 3 cycles.
//    -> busy stays 0, data stays 1, o is unchanged.
//  - Mid-frame reset: rst asserted in the 2nd SHIFT cycle.
//    -> next cycle: data=1, busy=0, o=0000, i_ready=1.
//    -> a new request is accepted normally afterwards.

Source files
------------

// File: rtl/priority_serial_tx.sv
// ---------------------------------------------------------------------------
// priority_serial_tx
//
// Priority-encodes an N_CH-wide request vector and sends the winner's binary
// index over one serial line. The highest set request bit wins.
//
// Each frame is sent in this order:
//   1. start bit (0)
//   2. the index bits, MSB first
//   3. an optional even-parity bit
//   4. a stop bit (1)
//
// The grant is latched on accept and holds until the next accept.
//
// Optional feature (compile-time macro):
//   PRIORITY_SERIAL_TX_PARITY_EN
//     When defined, a PARITY state follows SHIFT and sends ^idx.
//     When undefined, SHIFT goes straight to STOP.
//
// Parameters:
//   N_CH   number of request channels (>= 2)
//   IDX_W  index width, equal to $clog2(N_CH)
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset; aborts any frame in progress
//   i           request vector, sampled on accept
//   i_valid     request vector is valid
//   i_ready     block can accept a request this cycle (IDLE or STOP)
//   data        serial line, idles high (registered)
//   busy        frame in progress (registered)
//   o           latched one-hot grant of the last accepted frame
//   idx         latched binary index of the last accepted frame
//   frame_done  one-cycle pulse during the STOP cycle (registered)
// ---------------------------------------------------------------------------
module priority_serial_tx #(
    parameter int N_CH  = 4,
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_CH-1:0]  i,
    input  logic             i_valid,
    output logic             i_ready,
    output logic             data,
    output logic             busy,
    output logic [N_CH-1:0]  o,
    output logic [IDX_W-1:0] idx,
    output logic             frame_done
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        SHIFT,
`ifdef PRIORITY_SERIAL_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t            state_reg, state_next;
    logic [IDX_W-1:0]  cnt_reg, cnt_next;
    logic              data_reg, data_next;
    logic              busy_reg;
    logic              frame_done_reg;
    logic [N_CH-1:0]   o_reg;
    logic [IDX_W-1:0]  idx_reg;

    logic [N_CH-1:0]   win;
    logic [IDX_W-1:0]  enc_idx;
    logic [IDX_W-1:0]  shifted;
    logic              accept;

    // A request bit wins only when no higher-numbered bit is set.
    // This makes the grant one-hot by construction.
    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_win
            if (gi == N_CH - 1) begin : g_top
                assign win[gi] = i[gi];
            end else begin : g_low
                assign win[gi] = i[gi] & ~(|i[N_CH-1:gi+1]);
            end
        end
    endgenerate

    always_comb begin
        enc_idx = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (win[k]) begin
                enc_idx = IDX_W'(k);
            end
        end
    end

    // An accept in STOP chains the next frame with no idle gap.
    assign i_ready = (state_reg == IDLE) || (state_reg == STOP);
    assign accept  = i_valid && i_ready && (|i);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = START;
                end
            end
            START: begin
                state_next = SHIFT;
                cnt_next   = IDX_W'(IDX_W - 1);
            end
            SHIFT: begin
                if (cnt_reg == '0) begin
`ifdef PRIORITY_SERIAL_TX_PARITY_EN
                    state_next = PARITY;
`else
                    state_next = STOP;
`endif
                end else begin
                    cnt_next = cnt_reg - IDX_W'(1);
                end
            end
`ifdef PRIORITY_SERIAL_TX_PARITY_EN
            PARITY: begin
                state_next = STOP;
            end
`endif
            STOP: begin
                state_next = accept ? START : IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The outputs are registered from the next state.
    // So the line level always matches the state the FSM is in.
    // idx_reg is stable whenever the next state is SHIFT or PARITY,
    // because accepts only happen from IDLE or STOP.
    always_comb begin
        shifted   = idx_reg >> cnt_next;
        data_next = 1'b1;
        case (state_next)
            START:   data_next = 1'b0;
            SHIFT:   data_next = shifted[0];
`ifdef PRIORITY_SERIAL_TX_PARITY_EN
            PARITY:  data_next = ^idx_reg;
`endif
            default: data_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            data_reg       <= 1'b1;
            busy_reg       <= 1'b0;
            frame_done_reg <= 1'b0;
            o_reg          <= '0;
            idx_reg        <= '0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            data_reg       <= data_next;
            busy_reg       <= (state_next != IDLE);
            frame_done_reg <= (state_next == STOP);
            if (accept) begin
                o_reg   <= win;
                idx_reg <= enc_idx;
            end
        end
    end

    assign data       = data_reg;
    assign busy       = busy_reg;
    assign frame_done = frame_done_reg;
    assign o          = o_reg;
    assign idx        = idx_reg;

endmodule

// File: tb/tb_priority_serial_tx.sv
// ---------------------------------------------------------------------------
// tb_priority_serial_tx
//
// Directed, table-driven bench for priority_serial_tx with N_CH=4, IDX_W=2.
// The expected frames are hand-computed.
//
// Hand-written sequences cover:
//   - reset
//   - null requests
//   - back-to-back frames
//   - mid-frame reset
//
// Frame length follows PRIORITY_SERIAL_TX_PARITY_EN.
// ---------------------------------------------------------------------------
module tb_priority_serial_tx;

`ifdef PRIORITY_SERIAL_TX_PARITY_EN
    localparam int FLEN = 5;
`else
    localparam int FLEN = 4;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] i;
    logic       i_valid;
    logic       i_ready;
    logic       data;
    logic       busy;
    logic [3:0] o;
    logic [1:0] idx;
    logic       frame_done;

    int checks = 0;
    int errors = 0;

    priority_serial_tx #(.N_CH(4), .IDX_W(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .i          (i),
        .i_valid    (i_valid),
        .i_ready    (i_ready),
        .data       (data),
        .busy       (busy),
        .o          (o),
        .idx        (idx),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // e_bits = {start, idx[1], idx[0], stop}; e_par is the even-parity bit.
    typedef struct {
        logic [3:0] req;
        logic [1:0] e_idx;
        logic [3:0] e_o;
        logic [3:0] e_bits;
        logic       e_par;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Bit b of the frame on the line, in send order.
    function automatic logic exp_bit(input logic [3:0] bits, input logic par, input int b);
        if (b < 3) return bits[3-b];
        else if (b == FLEN - 1) return bits[0];
        else return par;
    endfunction

    task automatic wait_ready();
        for (int n = 0; n < 20 && !i_ready; n++) @(negedge clk);
        chk("wait_ready", {31'd0, i_ready}, 32'd1);
    endtask

    task automatic run_vec(input vec_t v, input int num);
        wait_ready();
        i       = v.req;
        i_valid = 1'b1;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        i       = 4'b0000;
        for (int b = 0; b < FLEN; b++) begin
            @(negedge clk);
            chk("data", {31'd0, data}, {31'd0, exp_bit(v.e_bits, v.e_par, b)});
            chk("busy", {31'd0, busy}, 32'd1);
            chk("frame_done", {31'd0, frame_done}, (b == FLEN - 1) ? 32'd1 : 32'd0);
        end
        chk("o", {28'd0, o}, {28'd0, v.e_o});
        chk("idx", {30'd0, idx}, {30'd0, v.e_idx});
        @(negedge clk);
        chk("idle_data", {31'd0, data}, 32'd1);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        $display("vec %0d: i=%b idx=%0d o=%b", num, v.req, idx, o);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] bb;
        logic [3:0] last_o;
        vec_t       v;

        tbl[0] = '{4'b0001, 2'd0, 4'b0001, 4'b0001, 1'b0};
        tbl[1] = '{4'b1010, 2'd3, 4'b1000, 4'b0111, 1'b0};
        tbl[2] = '{4'b0100, 2'd2, 4'b0100, 4'b0101, 1'b1};
        tbl[3] = '{4'b0110, 2'd2, 4'b0100, 4'b0101, 1'b1};
        tbl[4] = '{4'b0011, 2'd1, 4'b0010, 4'b0011, 1'b1};
        tbl[5] = '{4'b1111, 2'd3, 4'b1000, 4'b0111, 1'b0};

        // Reset
        rst     = 1'b1;
        i       = 4'b0000;
        i_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_data", {31'd0, data}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_o", {28'd0, o}, 32'd0);
        chk("rst_idx", {30'd0, idx}, 32'd0);
        chk("rst_ready", {31'd0, i_ready}, 32'd1);
        chk("rst_fd", {31'd0, frame_done}, 32'd0);
        $display("reset: data=%b busy=%b o=%b idx=%0d", data, busy, o, idx);
        rst = 1'b0;

        // Table-driven single frames
        for (int k = 0; k < 6; k++) run_vec(tbl[k], k);
        last_o = tbl[5].e_o;

        // Null request
        i       = 4'b0000;
        i_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("null_busy", {31'd0, busy}, 32'd0);
            chk("null_data", {31'd0, data}, 32'd1);
            chk("null_o", {28'd0, o}, {28'd0, last_o});
        end
        i_valid = 1'b0;
        $display("null: busy=%b data=%b o=%b", busy, data, o);

        // Back-to-back: 0100 then 0010 presented during STOP
`ifdef PRIORITY_SERIAL_TX_PARITY_EN
        bb = 10'b01011_00111;
`else
        bb = {8'b0101_0011, 2'b00};
`endif
        wait_ready();
        i       = 4'b0100;
        i_valid = 1'b1;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        i       = 4'b0000;
        for (int b = 0; b < 2 * FLEN; b++) begin
            @(negedge clk);
            if (b == FLEN) i_valid = 1'b0;
            chk("b2b_data", {31'd0, data}, {31'd0, bb[9-b]});
            chk("b2b_busy", {31'd0, busy}, 32'd1);
            if (b == FLEN - 1) begin
                chk("b2b_ready", {31'd0, i_ready}, 32'd1);
                chk("b2b_idx1", {30'd0, idx}, 32'd2);
                i       = 4'b0010;
                i_valid = 1'b1;
            end
        end
        i = 4'b0000;
        chk("b2b_idx2", {30'd0, idx}, 32'd1);
        chk("b2b_o2", {28'd0, o}, 32'd2);
        @(negedge clk);
        chk("b2b_idle", {31'd0, busy}, 32'd0);
        $display("back-to-back: idx=%0d o=%b", idx, o);

        // Mid-frame reset during the second SHIFT cycle
        wait_ready();
        i       = 4'b1010;
        i_valid = 1'b1;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        i       = 4'b0000;
        repeat (3) @(negedge clk);
        chk("mid_shift2", {31'd0, data}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_data", {31'd0, data}, 32'd1);
        chk("mid_busy", {31'd0, busy}, 32'd0);
        chk("mid_o", {28'd0, o}, 32'd0);
        chk("mid_idx", {30'd0, idx}, 32'd0);
        chk("mid_ready", {31'd0, i_ready}, 32'd1);
        $display("mid-frame reset: data=%b busy=%b o=%b", data, busy, o);
        v = tbl[4];
        run_vec(v, 6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
